// File: rtl/seq_div_2w_w_if.sv
// seq_div_2w_w_if: operand/result valid-ready bundle for the sequential 2W/W divider
interface seq_div_2w_w_if #(parameter int W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_div_2w_w.sv
// seq_div_2w_w: sequential unsigned restoring 2W/W divider; DIV_EARLY_BYPASS_EN adds a 1-cycle path when dividend < divisor
module seq_div_2w_w #(parameter int W = 8) (
    input logic         clk,
    input logic         rst_n,
    seq_div_2w_w_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W:0]    r_q, r_sh, r_nx;
    logic [W-1:0]  sh_q, q_q, q_nx, dvsr_q, quo_q, rem_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q, dbz_q, accept, ovf_in, byp, ge, last;

    assign accept = bus.in_valid && state_q == IDLE;
    assign ovf_in = bus.dividend[2*W-1:W] >= bus.divisor;
`ifdef DIV_EARLY_BYPASS_EN
    assign byp    = bus.dividend[2*W-1:W] == '0 && bus.dividend[W-1:0] < bus.divisor;
`else
    assign byp    = 1'b0;
`endif

    // one restoring step: shift in the next dividend bit, subtract if it fits
    assign r_sh = {r_q[W-1:0], sh_q[W-1]};
    assign ge   = r_sh >= {1'b0, dvsr_q};
    assign r_nx = ge ? r_sh - {1'b0, dvsr_q} : r_sh;
    assign q_nx = (q_q << 1) | W'(ge);
    assign last = cnt_q == CW'(W - 1);

    assign bus.in_ready    = state_q == IDLE;
    assign bus.out_valid   = state_q == DONE;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (ovf_in || byp) ? DONE : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // result registers only change when a new result is produced
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_q    <= '0;
            sh_q   <= '0;
            q_q    <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            dvsr_q <= bus.divisor;
            r_q    <= {1'b0, bus.dividend[2*W-1:W]};
            sh_q   <= bus.dividend[W-1:0];
            q_q    <= '0;
            cnt_q  <= '0;
            if (ovf_in) begin
                quo_q <= '1;
                rem_q <= '0;
                ovf_q <= 1'b1;
                dbz_q <= bus.divisor == '0;
            end else if (byp) begin
                quo_q <= '0;
                rem_q <= bus.dividend[W-1:0];
                ovf_q <= 1'b0;
                dbz_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            r_q   <= r_nx;
            sh_q  <= sh_q << 1;
            q_q   <= q_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                quo_q <= q_nx;
                rem_q <= r_nx[W-1:0];
                ovf_q <= 1'b0;
                dbz_q <= 1'b0;
            end
        end
endmodule

// File: tb/tb_seq_div_2w_w.sv
// tb_seq_div_2w_w: vector table, corner sequences and random operands against an arithmetic divider model
module tb_seq_div_2w_w;
    localparam int W = 8;
`ifdef DIV_EARLY_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int SMALL_LAT = BYP ? 0 : W;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_div_2w_w_if #(.W(W)) bus ();
    seq_div_2w_w #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  ds;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
        logic        z;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // accept edge counts as 0; lat is the number of further edges before out_valid is seen
    task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] ds,
                         input logic [7:0] eq, input logic [7:0] er, input logic eo, input logic ez,
                         input int el, input int hold);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.dividend  = dd;
        bus.divisor   = ds;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        @(negedge clk);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'({bus.out_valid, bus.in_ready}), 32'b10);
            chk({tag, "_hold_res"}, {14'd0, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder},
                {14'd0, eo, ez, eq, er});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid_ready"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk({tag, "_results"}, {14'd0, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder}, 32'd0);
    endtask

    initial begin
        logic [15:0] dd;
        logic [7:0]  ds;
        logic [7:0]  eq, er;
        logic        eo, ez;
        int          el;
        checks = 0;
        errors = 0;

        tv[0] = '{16'd1000,  8'd7,    8'd142,  8'd6,   1'b0, 1'b0, W,         0};
        tv[1] = '{16'hFFFF,  8'hFF,   8'hFF,   8'd0,   1'b1, 1'b0, 0,         0};
        tv[2] = '{16'h1234,  8'd0,    8'hFF,   8'd0,   1'b1, 1'b1, 0,         0};
        tv[3] = '{16'd200,   8'd10,   8'd20,   8'd0,   1'b0, 1'b0, W,         5};
        tv[4] = '{16'd5,     8'd9,    8'd0,    8'd5,   1'b0, 1'b0, SMALL_LAT, 0};
        tv[5] = '{16'h00FF,  8'd1,    8'hFF,   8'd0,   1'b0, 1'b0, W,         1};
        tv[6] = '{16'h0100,  8'd1,    8'hFF,   8'd0,   1'b1, 1'b0, 0,         2};
        tv[7] = '{16'd0,     8'd5,    8'd0,    8'd0,   1'b0, 1'b0, SMALL_LAT, 0};
        tv[8] = '{16'hFEFF,  8'hFF,   8'hFF,   8'd254, 1'b0, 1'b0, W,         0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), tv[i].dd, tv[i].ds, tv[i].q, tv[i].r,
                  tv[i].o, tv[i].z, tv[i].lat, tv[i].hold);

        // asynchronous reset during RUN, with the previous result still on the outputs
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk_reset_outputs("rst_after");
        do_op("rst_redo", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, W, 0);

        for (int k = 0; k < 200; k++) begin
            ds = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       dd = 16'($urandom);
                1:       dd = 16'($urandom_range(0, 300));
                default: dd = {8'($urandom_range(0, (ds == 0) ? 0 : ds - 1)), 8'($urandom)};
            endcase
            eo = (ds == 0) || (int'(dd) / 256 >= int'(ds));
            ez = ds == 0;
            eq = eo ? 8'hFF : 8'(int'(dd) / int'(ds));
            er = eo ? 8'd0  : 8'(int'(dd) % int'(ds));
            el = (eo || (BYP && int'(dd) < int'(ds))) ? 0 : W;
            do_op($sformatf("rnd%0d", k), dd, ds, eq, er, eo, ez, el, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
